// File: rtl/fdu_por_sequencer_if.sv
// Handshake bundle between the fdu health logic and the POR sequencer.
// The master side (fdu / testbench) drives unit status; the slave side is the sequencer.
interface fdu_por_sequencer_if;
   logic       enable;
   logic [1:0] healthy;
   logic [1:0] prime;
   logic [1:0] clr_lockout;
   logic [1:0] por_n;
   logic [1:0] lockout;
   logic       busy;
   logic       active_unit;

   modport master (
      output enable,
      output healthy,
      output prime,
      output clr_lockout,
      input  por_n,
      input  lockout,
      input  busy,
      input  active_unit
   );

   modport slave (
      input  enable,
      input  healthy,
      input  prime,
      input  clr_lockout,
      output por_n,
      output lockout,
      output busy,
      output active_unit
   );
endinterface

// File: rtl/fdu_por_sequencer.sv
// Power-on-reset recovery sequencer for two fdu units sharing one POR timer.
// Pulses an unhealthy non-prime unit, waits a holdoff window, retries, and
// locks the unit out after MAX_RETRY failed attempts until software clears it.
module fdu_por_sequencer #(
   parameter int unsigned POR_CYCLES     = 16,
   parameter int unsigned HOLDOFF_CYCLES = 1024,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned CNT_W          = 16
) (
   input logic                clk,
   input logic                reset,
   fdu_por_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] PorLast     = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldoffLast = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [1:0]       MaxRetry    = 2'(MAX_RETRY);

   typedef enum logic [1:0] {
      StIdle,
      StAssert,
      StHoldoff
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             unit_q, unit_d;
   logic             last_grant_q, last_grant_d;
   logic [1:0]       lockout_q, lockout_d;
   logic [1:0][1:0]  retry_q, retry_d;

   logic [1:0]       req;
   logic             grant;
   logic [1:0]       retry_inc;

   // Only meaningful in idle; prime and locked-out units never request.
   assign req = {2{bus.enable}} & ~bus.healthy & ~bus.prime & ~lockout_q;

   // Round-robin pick between the two requesters; a lone requester always wins.
   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last_grant_q;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

   // Saturating retry increment for the unit currently owning the timer.
   assign retry_inc = (retry_q[unit_q] == MaxRetry) ? MaxRetry : retry_q[unit_q] + 2'd1;

   // Next-state logic: software clears first so a same-cycle lockout set overrides it.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q + CNT_W'(1);
      unit_d       = unit_q;
      last_grant_d = last_grant_q;
      lockout_d    = lockout_q;
      retry_d      = retry_q;

      for (int i = 0; i < 2; i++) begin
         if (bus.clr_lockout[i]) begin
            lockout_d[i] = 1'b0;
            retry_d[i]   = 2'd0;
         end
      end

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (|req) begin
               state_d      = StAssert;
               unit_d       = grant;
               last_grant_d = grant;
            end
         end
         StAssert: begin
            if (bus.prime[unit_q]) begin
               // Unit became prime: drop the pulse, keep its retry count.
               state_d = StIdle;
               timer_d = '0;
            end else if (timer_q == PorLast) begin
               state_d = StHoldoff;
               timer_d = '0;
            end
         end
         StHoldoff: begin
            if (bus.prime[unit_q]) begin
               state_d = StIdle;
               timer_d = '0;
            end else if (bus.healthy[unit_q]) begin
               retry_d[unit_q] = 2'd0;
               state_d         = StIdle;
               timer_d         = '0;
            end else if (timer_q == HoldoffLast) begin
               retry_d[unit_q] = retry_inc;
               if (retry_inc == MaxRetry) begin
                  lockout_d[unit_q] = 1'b1;
               end
               state_d = StIdle;
               timer_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset; reset also ends any pulse in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         unit_q       <= 1'b0;
         last_grant_q <= 1'b1;
         lockout_q    <= 2'b00;
         retry_q      <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         unit_q       <= unit_d;
         last_grant_q <= last_grant_d;
         lockout_q    <= lockout_d;
         retry_q      <= retry_d;
      end
   end

   // POR is low exactly while in assert, so only one bit can ever be low.
   assign bus.por_n       = (state_q == StAssert) ? (unit_q ? 2'b01 : 2'b10) : 2'b11;
   assign bus.lockout     = lockout_q;
   assign bus.busy        = (state_q != StIdle);
   assign bus.active_unit = unit_q;

endmodule

// File: tb/tb_fdu_por_sequencer.sv
// Directed bench for fdu_por_sequencer with POR_CYCLES=4, HOLDOFF_CYCLES=20, MAX_RETRY=2.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_fdu_por_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fdu_por_sequencer_if bus_if ();

   fdu_por_sequencer #(
      .POR_CYCLES    (4),
      .HOLDOFF_CYCLES(20),
      .MAX_RETRY     (2),
      .CNT_W         (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_inputs(input logic en, input logic [1:0] h, input logic [1:0] p);
      bus_if.enable      = en;
      bus_if.healthy     = h;
      bus_if.prime       = p;
      bus_if.clr_lockout = 2'b00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      set_inputs(1'b1, 2'b11, 2'b00);
      do_reset();
      checks++;
      if (bus_if.por_n !== 2'b11) begin
         errors++; $display("FAIL reset_por_n got %b want 11", bus_if.por_n);
      end
      checks++;
      if (bus_if.lockout !== 2'b00) begin
         errors++; $display("FAIL reset_lockout got %b want 00", bus_if.lockout);
      end
      checks++;
      if (bus_if.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", bus_if.busy);
      end
      checks++;
      if (bus_if.active_unit !== 1'b0) begin
         errors++; $display("FAIL reset_active_unit got %b want 0", bus_if.active_unit);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus_if.por_n !== 2'b11 || bus_if.busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL reset_hold bad_cycles %0d want 0", bad);
      end
   endtask

   task automatic test_single_recovery();
      int n;
      int bad;
      set_inputs(1'b1, 2'b10, 2'b10);
      step();
      checks++;
      if (bus_if.por_n !== 2'b10) begin
         errors++; $display("FAIL single_start got %b want 10", bus_if.por_n);
      end
      checks++;
      if (bus_if.busy !== 1'b1 || bus_if.active_unit !== 1'b0) begin
         errors++;
         $display("FAIL single_owner busy %b unit %b want 1 0", bus_if.busy, bus_if.active_unit);
      end
      n = 0;
      while (bus_if.por_n === 2'b10 && n < 10) begin
         n++;
         step();
      end
      checks++;
      if (n != 4) begin
         errors++; $display("FAIL single_pulse_len got %0d want 4", n);
      end
      // Now observing holdoff cycle 1; advance to holdoff cycle 5.
      repeat (4) step();
      checks++;
      if (bus_if.busy !== 1'b1 || bus_if.por_n !== 2'b11) begin
         errors++;
         $display("FAIL single_holdoff busy %b por_n %b want 1 11", bus_if.busy, bus_if.por_n);
      end
      bus_if.healthy = 2'b11;
      step();
      checks++;
      if (bus_if.busy !== 1'b0) begin
         errors++; $display("FAIL single_recover_busy got %b want 0", bus_if.busy);
      end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus_if.por_n !== 2'b11) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL single_no_second_pulse low_cycles %0d want 0", bad);
      end
   endtask

   task automatic test_lockout();
      logic prev;
      int   nrise;
      int   r0;
      int   r1;
      set_inputs(1'b1, 2'b10, 2'b10);
      prev  = 1'b1;
      nrise = 0;
      r0    = -1;
      r1    = -1;
      for (int c = 0; c < 150; c++) begin
         step();
         if (c == 49) begin
            bus_if.clr_lockout = 2'b00;
            // Clear arrived on the same edge as the second timeout: set must win.
            checks++;
            if (bus_if.lockout !== 2'b01) begin
               errors++; $display("FAIL lockout_set_wins got %b want 01", bus_if.lockout);
            end
         end
         if (!prev && bus_if.por_n[0]) begin
            nrise++;
            if (nrise == 1) r0 = c;
            else if (nrise == 2) r1 = c;
         end
         prev = bus_if.por_n[0];
         if (c == 48) bus_if.clr_lockout = 2'b01;
      end
      checks++;
      if (nrise != 2) begin
         errors++; $display("FAIL lockout_pulse_count got %0d want 2", nrise);
      end
      checks++;
      if (r0 != 4) begin
         errors++; $display("FAIL lockout_first_rise got %0d want 4", r0);
      end
      // 4 assert + 20 holdoff + 1 idle re-arbitration cycle between rising edges.
      checks++;
      if (r1 - r0 != 25) begin
         errors++; $display("FAIL lockout_rise_spacing got %0d want 25", r1 - r0);
      end
      checks++;
      if (bus_if.lockout !== 2'b01 || bus_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL lockout_final lockout %b busy %b want 01 0", bus_if.lockout, bus_if.busy);
      end
      bus_if.clr_lockout = 2'b01;
      step();
      bus_if.clr_lockout = 2'b00;
      checks++;
      if (bus_if.lockout !== 2'b00) begin
         errors++; $display("FAIL lockout_clear got %b want 00", bus_if.lockout);
      end
      step();
      checks++;
      if (bus_if.por_n !== 2'b10) begin
         errors++; $display("FAIL lockout_restart got %b want 10", bus_if.por_n);
      end
   endtask

   task automatic test_arbitration();
      logic [1:0] prev;
      int         order[4];
      int         exp_order[4];
      int         npulse;
      int         both_low;
      exp_order = '{0, 1, 0, 1};
      order     = '{-1, -1, -1, -1};
      set_inputs(1'b1, 2'b00, 2'b00);
      do_reset();
      prev     = 2'b11;
      npulse   = 0;
      both_low = 0;
      for (int c = 0; c < 140; c++) begin
         step();
         if (bus_if.por_n === 2'b00) both_low++;
         if (prev === 2'b11 && bus_if.por_n !== 2'b11) begin
            if (npulse < 4) order[npulse] = bus_if.por_n[0] ? 1 : 0;
            npulse++;
         end
         prev = bus_if.por_n;
      end
      checks++;
      if (npulse != 4) begin
         errors++; $display("FAIL arb_pulse_count got %0d want 4", npulse);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (order[i] != exp_order[i]) begin
            errors++; $display("FAIL arb_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
         end
      end
      checks++;
      if (both_low != 0) begin
         errors++; $display("FAIL arb_both_low cycles %0d want 0", both_low);
      end
      checks++;
      if (bus_if.lockout !== 2'b11) begin
         errors++; $display("FAIL arb_lockout got %b want 11", bus_if.lockout);
      end
   endtask

   task automatic test_prime_guard();
      logic prev0;
      int   u1_low;
      int   u0_starts;
      set_inputs(1'b1, 2'b00, 2'b10);
      do_reset();
      prev0     = 1'b1;
      u1_low    = 0;
      u0_starts = 0;
      for (int c = 0; c < 80; c++) begin
         step();
         if (bus_if.por_n[1] !== 1'b1) u1_low++;
         if (prev0 && !bus_if.por_n[0]) u0_starts++;
         prev0 = bus_if.por_n[0];
      end
      checks++;
      if (u1_low != 0) begin
         errors++; $display("FAIL prime_unit1_pulsed cycles %0d want 0", u1_low);
      end
      checks++;
      if (u0_starts != 2) begin
         errors++; $display("FAIL prime_unit0_pulses got %0d want 2", u0_starts);
      end
      do_reset();
      step();
      step();
      checks++;
      if (bus_if.por_n !== 2'b10) begin
         errors++; $display("FAIL prime_mid_assert got %b want 10", bus_if.por_n);
      end
      bus_if.prime = 2'b01;
      step();
      checks++;
      if (bus_if.por_n !== 2'b11 || bus_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL prime_abort por_n %b busy %b want 11 0", bus_if.por_n, bus_if.busy);
      end
      bus_if.enable = 1'b0;
   endtask

   task automatic test_reset_mid_assert();
      logic [1:0] prev;
      int         npulse;
      int         c;
      set_inputs(1'b1, 2'b00, 2'b00);
      do_reset();
      prev   = 2'b11;
      npulse = 0;
      c      = 0;
      while (npulse < 4 && c < 200) begin
         step();
         if (prev === 2'b11 && bus_if.por_n !== 2'b11) npulse++;
         prev = bus_if.por_n;
         c++;
      end
      checks++;
      if (npulse != 4) begin
         errors++; $display("FAIL rst_mid_find_pulse got %0d want 4", npulse);
      end
      checks++;
      if (bus_if.lockout !== 2'b01) begin
         errors++; $display("FAIL rst_mid_pre_lockout got %b want 01", bus_if.lockout);
      end
      step();
      checks++;
      if (bus_if.por_n !== 2'b01) begin
         errors++; $display("FAIL rst_mid_pulse_cycle2 got %b want 01", bus_if.por_n);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (bus_if.por_n !== 2'b11 || bus_if.busy !== 1'b0 || bus_if.lockout !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid_state por_n %b busy %b lockout %b want 11 0 00",
                  bus_if.por_n, bus_if.busy, bus_if.lockout);
      end
      // Unit 1 had one failed attempt; after reset one more failure must not lock it out.
      set_inputs(1'b1, 2'b00, 2'b01);
      repeat (40) step();
      checks++;
      if (bus_if.lockout !== 2'b00) begin
         errors++; $display("FAIL rst_mid_retry_cleared lockout %b want 00", bus_if.lockout);
      end
   endtask

   initial begin
      set_inputs(1'b0, 2'b11, 2'b00);
      test_reset();
      test_single_recovery();
      test_lockout();
      test_arbitration();
      test_prime_guard();
      test_reset_mid_assert();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
